// File: rtl/uart_baud_scheduler_if.sv
// Configuration handshake bundle for uart_baud_scheduler.
// master: the requester that proposes a new divisor.
// slave : the scheduler that accepts it and reports the outcome.
interface uart_baud_scheduler_if #(
    parameter int unsigned DIV_W = 16
);
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_err;
    logic             cfg_timeout;

    modport master (
        output cfg_div,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err,
        input  cfg_timeout
    );

    modport slave (
        input  cfg_div,
        input  cfg_valid,
        output cfg_ready,
        output cfg_done,
        output cfg_err,
        output cfg_timeout
    );
endinterface

// File: rtl/uart_baud_scheduler.sv
// Runtime baud-rate scheduler: derives the oversample tick and bit tick from a
// programmable divisor and swaps divisors only while both channels are idle,
// restarting the phase so no frame straddles two rates.
// Optional feature macro: UART_BAUD_TIMEOUT_EN adds a drain timer that forces
// the load after TIMEOUT_CYC cycles of waiting.
module uart_baud_scheduler #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned OVS         = 16,
    parameter int unsigned DEFAULT_DIV = 78,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    uart_baud_scheduler_if.slave cfg,
    input  logic                 tx_busy,
    input  logic                 rx_busy,
    output logic                 drain_req,
    output logic                 os_tick,
    output logic                 bit_tick,
    output logic [DIV_W-1:0]     cur_div
);

    localparam int unsigned BIT_W = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        LOAD
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] os_cnt;
    logic [DIV_W-1:0] os_last;
    logic [BIT_W-1:0] bit_cnt;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             os_wrap;
    logic             bit_wrap;
    logic             idle;

`ifdef UART_BAUD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] drain_cnt;
    logic            to_pend;
    logic            timeout_q;

    assign cfg.cfg_timeout = timeout_q;
`else
    // No timer in this build; the comparison only keeps the parameter referenced.
    assign cfg.cfg_timeout = (TIMEOUT_CYC == 0) & 1'b0;
`endif

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_done  = done_q;
    assign cfg.cfg_err   = err_q;

    // Wrap detection for the two tick counters and the combined idle condition.
    always_comb begin
        os_last  = cur_div - DIV_W'(1);
        os_wrap  = (os_cnt == os_last);
        bit_wrap = (bit_cnt == BIT_W'(OVS - 1));
        idle     = !tx_busy && !rx_busy;
    end

    // Tick generation plus the RUN/DRAIN/LOAD sequencer with registered outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            cur_div   <= DIV_W'(DEFAULT_DIV);
            pend_div  <= '0;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            ready_q   <= 1'b1;
            drain_req <= 1'b0;
            os_tick   <= 1'b0;
            bit_tick  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_BAUD_TIMEOUT_EN
            drain_cnt <= '0;
            to_pend   <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else begin
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef UART_BAUD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif

            // The load cycle restarts the phase and swallows any wrap due now.
            if (state == LOAD) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
            end else if (os_wrap) begin
                os_cnt  <= '0;
                os_tick <= 1'b1;
                if (bit_wrap) begin
                    bit_cnt  <= '0;
                    bit_tick <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end else begin
                os_cnt <= os_cnt + DIV_W'(1);
            end

            case (state)
                RUN: begin
                    if (cfg.cfg_valid && ready_q) begin
                        if (cfg.cfg_div < DIV_W'(2)) begin
                            err_q <= 1'b1;
                        end else begin
                            pend_div  <= cfg.cfg_div;
                            state     <= DRAIN;
                            ready_q   <= 1'b0;
                            drain_req <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
`ifdef UART_BAUD_TIMEOUT_EN
                    if (idle) begin
                        state     <= LOAD;
                        drain_cnt <= '0;
                    end else if (drain_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        state     <= LOAD;
                        drain_cnt <= '0;
                        to_pend   <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + TO_W'(1);
                    end
`else
                    if (idle) begin
                        state <= LOAD;
                    end
`endif
                end
                LOAD: begin
                    cur_div   <= pend_div;
                    done_q    <= 1'b1;
                    ready_q   <= 1'b1;
                    drain_req <= 1'b0;
                    state     <= RUN;
`ifdef UART_BAUD_TIMEOUT_EN
                    timeout_q <= to_pend;
                    to_pend   <= 1'b0;
`endif
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_baud_scheduler.sv
// Scoreboard bench for uart_baud_scheduler (DEFAULT_DIV=4, OVS=4).
// Stimulus pushes every strobe it expects (kind, edge number, cur_div) into a
// queue; an independent monitor matches each strobe the DUT raises.
module tb_uart_baud_scheduler;

    localparam int DIV_W = 16;

    typedef struct {
        int kind;
        int at;
        int div;
    } exp_t;

    logic             sys_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             tx_busy = 1'b0;
    logic             rx_busy = 1'b0;
    logic             drain_req;
    logic             os_tick;
    logic             bit_tick;
    logic [DIV_W-1:0] cur_div;

    int   edge_no = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    string names [5] = '{"os_tick", "bit_tick", "cfg_done", "cfg_err", "cfg_timeout"};

    uart_baud_scheduler_if #(.DIV_W(DIV_W)) cfg_bus ();

    uart_baud_scheduler #(
        .DIV_W       (DIV_W),
        .OVS         (4),
        .DEFAULT_DIV (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .cfg       (cfg_bus),
        .tx_busy   (tx_busy),
        .rx_busy   (rx_busy),
        .drain_req (drain_req),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
        .cur_div   (cur_div)
    );

    always #5 sys_clk = ~sys_clk;

    // Rising edges counted from reset release; edge 1 is the first one after it.
    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) edge_no <= 0;
        else          edge_no <= edge_no + 1;
    end

    function automatic void push(input int kind, input int at, input int div);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.div  = div;
        exp_q.push_back(e);
    endfunction

    function automatic void push_range(input int kind, input int first, input int step,
                                       input int last, input int div);
        for (int e = first; e <= last; e += step) push(kind, e, div);
    endfunction

    task automatic match(input int k);
        int idx;
        idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].kind == k && exp_q[i].at == edge_no) idx = i;
        end
        n_checks++;
        if (idx < 0) begin
            $display("FAIL %s unexpected at edge %0d (cur_div %0d), required none", names[k], edge_no, cur_div);
        end else begin
            if (cur_div == DIV_W'(exp_q[idx].div)) n_pass++;
            else $display("FAIL %s at edge %0d cur_div got %0d required %0d", names[k], edge_no, cur_div, exp_q[idx].div);
            exp_q.delete(idx);
        end
    endtask

    task automatic flush(input int upto);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= upto) begin
                n_checks++;
                $display("FAIL %s missing: got none, required at edge %0d", names[exp_q[i].kind], exp_q[i].at);
                exp_q.delete(i);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s at edge %0d got %0d required %0d", name, edge_no, got, req);
    endtask

    task automatic wait_edge(input int e);
        int guard;
        guard = 0;
        while (edge_no < e && guard < 10000) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
        if (edge_no != e) begin
            n_checks++;
            $display("FAIL wait_edge reached %0d required %0d", edge_no, e);
        end
    endtask

    task automatic finish_phase(input int e);
        @(negedge sys_clk);
        #1;
        flush(e);
    endtask

    // Monitor: every strobe the DUT raises must match a queued expectation.
    always @(negedge sys_clk) begin : monitor
        logic [4:0] s;
        if (reset_n) begin
            s = {cfg_bus.cfg_timeout, cfg_bus.cfg_err, cfg_bus.cfg_done, bit_tick, os_tick};
            for (int k = 0; k < 5; k++) if (s[k] === 1'b1) match(k);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset cur_div", 32'(cur_div), 4);
        chk("reset cfg_ready", 32'(cfg_bus.cfg_ready), 1);
        chk("reset drain_req", 32'(drain_req), 0);
        chk("reset strobes", 32'({os_tick, bit_tick, cfg_bus.cfg_done, cfg_bus.cfg_err, cfg_bus.cfg_timeout}), 0);
        @(negedge sys_clk);
        reset_n = 1'b1;

        // Free-running ticks at the reset divisor.
        push_range(0, 4, 4, 84, 4);
        push_range(1, 16, 16, 80, 4);

        // Request div 3 while TX is busy for 50 cycles; ignored request held mid-drain.
        push(2, 86, 3);
        push_range(0, 89, 3, 104, 3);
        push(1, 98, 3);
        wait_edge(33);
        cfg_bus.cfg_div = 3; cfg_bus.cfg_valid = 1'b1; tx_busy = 1'b1;
        wait_edge(34);
        cfg_bus.cfg_valid = 1'b0;
        chk("drain cfg_ready", 32'(cfg_bus.cfg_ready), 0);
        chk("drain drain_req", 32'(drain_req), 1);
        wait_edge(40);
        cfg_bus.cfg_div = 2; cfg_bus.cfg_valid = 1'b1;
        wait_edge(50);
        rx_busy = 1'b1;
        wait_edge(60);
        chk("busy drain_req", 32'(drain_req), 1);
        chk("busy cur_div", 32'(cur_div), 4);
        rx_busy = 1'b0;
        wait_edge(70);
        cfg_bus.cfg_valid = 1'b0;
        wait_edge(84);
        tx_busy = 1'b0;
        wait_edge(85);
        chk("pre-load drain_req", 32'(drain_req), 1);
        wait_edge(86);
        chk("loaded cur_div", 32'(cur_div), 3);
        chk("loaded cfg_ready", 32'(cfg_bus.cfg_ready), 1);
        chk("loaded drain_req", 32'(drain_req), 0);

        // Illegal divisor is rejected.
        push(3, 100, 3);
        wait_edge(99);
        cfg_bus.cfg_div = 1; cfg_bus.cfg_valid = 1'b1;
        wait_edge(100);
        cfg_bus.cfg_valid = 1'b0;
        chk("err drain_req", 32'(drain_req), 0);
        chk("err cfg_ready", 32'(cfg_bus.cfg_ready), 1);

        // Same divisor again: drains and realigns the phase.
        push(2, 106, 3);
        push_range(0, 109, 3, 121, 3);
        push(1, 118, 3);
        wait_edge(103);
        cfg_bus.cfg_div = 3; cfg_bus.cfg_valid = 1'b1;
        wait_edge(104);
        cfg_bus.cfg_valid = 1'b0;
        wait_edge(106);
        chk("realign cur_div", 32'(cur_div), 3);

        // Idle change to div 5; the old-rate wrap at 121 still fires in DRAIN.
        push(2, 122, 5);
        push_range(0, 127, 5, 142, 5);
        push(1, 142, 5);
        wait_edge(119);
        cfg_bus.cfg_div = 5; cfg_bus.cfg_valid = 1'b1;
        wait_edge(120);
        cfg_bus.cfg_valid = 1'b0;
        wait_edge(122);
        chk("idle cur_div", 32'(cur_div), 5);

        // Reset in the middle of a drain toward div 9.
        wait_edge(143);
        cfg_bus.cfg_div = 9; cfg_bus.cfg_valid = 1'b1; tx_busy = 1'b1;
        wait_edge(144);
        cfg_bus.cfg_valid = 1'b0;
        wait_edge(146);
        chk("div9 drain_req", 32'(drain_req), 1);
        finish_phase(146);
        reset_n = 1'b0;
        tx_busy = 1'b0;
        #1;
        chk("mid-drain reset cur_div", 32'(cur_div), 4);
        chk("mid-drain reset cfg_ready", 32'(cfg_bus.cfg_ready), 1);
        chk("mid-drain reset drain_req", 32'(drain_req), 0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;

        push_range(0, 4, 4, 16, 4);
        push(1, 16, 4);
        wait_edge(1);
        chk("post-reset cur_div", 32'(cur_div), 4);
`ifdef UART_BAUD_TIMEOUT_EN
        // RX stuck busy: forced load after 100 drain cycles.
        push_range(0, 20, 4, 116, 4);
        push_range(1, 32, 16, 112, 4);
        push(2, 119, 6);
        push(4, 119, 6);
        push_range(0, 125, 6, 143, 6);
        push(1, 143, 6);
        wait_edge(17);
        cfg_bus.cfg_div = 6; cfg_bus.cfg_valid = 1'b1; rx_busy = 1'b1;
        wait_edge(18);
        cfg_bus.cfg_valid = 1'b0;
        wait_edge(60);
        chk("stuck drain_req", 32'(drain_req), 1);
        chk("stuck cfg_ready", 32'(cfg_bus.cfg_ready), 0);
        wait_edge(119);
        chk("timeout cur_div", 32'(cur_div), 6);
        chk("timeout drain_req", 32'(drain_req), 0);
        wait_edge(145);
        finish_phase(145);
        rx_busy = 1'b0;
`else
        push(0, 20, 4);
        wait_edge(20);
        finish_phase(20);
`endif
        flush(32'h7fffffff);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
